// File: rtl/evm_pkg.sv
// Shared definitions for the EVM ballot controller: state encoding and candidate count.
package evm_pkg;

  localparam int NUM_CAND = 3;
  localparam int STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 3'd0,
    S_READY    = 3'd1,
    S_ARMED    = 3'd2,
    S_DEBOUNCE = 3'd3,
    S_CAST     = 3'd4,
    S_WAIT_REL = 3'd5,
    S_WAIT_CLR = 3'd6
  } state_t;

endpackage

// File: rtl/evm_down_counter.sv
// Loadable down counter that stops at zero; load wins over enable.
module evm_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Ballot controller: debounces one candidate press per authorised ballot and strobes the EVM.
// Vote appears DEBOUNCE_CYCLES+1 cycles after the first sampled single press.
module evm_ballot_ctrl
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             session_open,
  input  logic             voter_auth,
  input  logic [2:0]       vote_btn,
  output logic [2:0]       vote_pulse,
  output logic             candidate_ready,
  output logic             reject_pulse,
  output logic             timeout_pulse,
  output logic [CNT_W-1:0] cast_count,
  output logic [2:0]       state_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  // Timeout is loaded one short so the abandon decision lands on the TIMEOUT_CYCLES-th armed cycle.
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  state_t              state, state_nxt;
  logic [NUM_CAND-1:0] latched;
  logic                multi;
  logic                db_load, db_zero, to_load, to_zero;
  logic                reject_nxt, timeout_nxt;

  assign multi = ($countones(vote_btn) > 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    db_load     = 1'b0;
    to_load     = 1'b0;
    reject_nxt  = 1'b0;
    timeout_nxt = 1'b0;
    if ((state != S_IDLE) && !session_open) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (session_open) state_nxt = S_READY;
        S_READY: begin
          if (voter_auth) begin
            state_nxt = S_ARMED;
            to_load   = 1'b1;
          end
        end
        S_ARMED, S_DEBOUNCE: begin
          if (to_zero) begin
            state_nxt   = S_READY;
            timeout_nxt = 1'b1;
          end else if (multi) begin
            state_nxt  = S_WAIT_CLR;
            reject_nxt = 1'b1;
          end else if (state == S_ARMED) begin
            if (vote_btn != '0) begin
              state_nxt = S_DEBOUNCE;
              db_load   = 1'b1;
            end
          end else if (vote_btn == latched) begin
            if (db_zero) state_nxt = S_CAST;
          end else begin
            state_nxt = S_ARMED;
          end
        end
        S_CAST:     state_nxt = S_WAIT_REL;
        S_WAIT_REL: if (vote_btn == '0) state_nxt = S_READY;
        S_WAIT_CLR: begin
          if (vote_btn == '0) begin
            state_nxt = S_ARMED;
            to_load   = 1'b1;
          end
        end
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latched       <= '0;
      cast_count    <= '0;
      reject_pulse  <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      reject_pulse  <= reject_nxt;
      timeout_pulse <= timeout_nxt;
      if (db_load) latched <= vote_btn;
      if ((state == S_IDLE) && (state_nxt == S_READY)) begin
        cast_count <= '0;
      end else if ((state == S_CAST) && (cast_count != '1)) begin
        cast_count <= cast_count + CNT_W'(1);
      end
    end
  end

  evm_down_counter #(.W(DB_W)) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .load     (db_load),
    .load_val (DB_LOAD),
    .en       (state == S_DEBOUNCE),
    .zero     (db_zero)
  );

  evm_down_counter #(.W(TO_W)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (TO_LOAD),
    .en       ((state == S_ARMED) || (state == S_DEBOUNCE)),
    .zero     (to_zero)
  );

  // CAST lasts one cycle, so a state-decoded strobe is exactly one cycle wide.
  assign vote_pulse      = (state == S_CAST) ? latched : '0;
  assign candidate_ready = (state == S_ARMED) || (state == S_DEBOUNCE);
  assign state_o         = state;

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Self-checking bench for evm_ballot_ctrl: directed scenarios plus random traffic against a ballot model.
module tb_evm_ballot_ctrl;
  import evm_pkg::*;

  localparam int DEB  = 4;
  localparam int TMO  = 20;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  // Model ballot phases (bench-local meaning, unrelated to the DUT encoding).
  localparam int M_OFF = 0, M_WAIT_AUTH = 1, M_CHOOSING = 2, M_HOLDING = 3,
                 M_EMIT = 4, M_DRAIN_DONE = 5, M_DRAIN_RETRY = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          session_open;
  logic          voter_auth;
  logic [2:0]    vote_btn;
  logic [2:0]    vote_pulse;
  logic          candidate_ready;
  logic          reject_pulse;
  logic          timeout_pulse;
  logic [CW-1:0] cast_count;
  logic [2:0]    state_o;

  int checks   = 0;
  int failures = 0;

  int         m_ph, m_hold, m_age, m_count;
  logic [2:0] m_choice;
  bit         m_rej, m_to;

  always #5 clk = ~clk;

  evm_ballot_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TMO),
    .CNT_W           (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .session_open    (session_open),
    .voter_auth      (voter_auth),
    .vote_btn        (vote_btn),
    .vote_pulse      (vote_pulse),
    .candidate_ready (candidate_ready),
    .reject_pulse    (reject_pulse),
    .timeout_pulse   (timeout_pulse),
    .cast_count      (cast_count),
    .state_o         (state_o)
  );

  task automatic model_reset();
    m_ph = M_OFF; m_hold = 0; m_age = 0; m_count = 0;
    m_choice = 3'b000; m_rej = 0; m_to = 0;
  endtask

  // One clock of ballot rules: hold counts held samples, age counts armed cycles.
  task automatic model_step(input bit open, input bit auth, input logic [2:0] btn);
    int n;
    n = $countones(btn);
    m_rej = 0;
    m_to  = 0;
    if (m_ph == M_EMIT) m_count = (m_count == CMAX) ? CMAX : m_count + 1;
    if (m_ph != M_OFF && !open) begin
      m_ph = M_OFF;
    end else begin
      case (m_ph)
        M_OFF:       if (open) begin m_ph = M_WAIT_AUTH; m_count = 0; end
        M_WAIT_AUTH: if (auth) begin m_ph = M_CHOOSING; m_age = 0; end
        M_CHOOSING, M_HOLDING: begin
          if (m_age == TMO - 1) begin
            m_to = 1; m_ph = M_WAIT_AUTH;
          end else begin
            m_age++;
            if (n >= 2) begin
              m_rej = 1; m_ph = M_DRAIN_RETRY;
            end else if (m_ph == M_CHOOSING) begin
              if (n == 1) begin m_choice = btn; m_hold = 0; m_ph = M_HOLDING; end
            end else if (btn == m_choice) begin
              if (m_hold == DEB) m_ph = M_EMIT; else m_hold++;
            end else begin
              m_ph = M_CHOOSING;
            end
          end
        end
        M_EMIT:        m_ph = M_DRAIN_DONE;
        M_DRAIN_DONE:  if (btn == 3'b000) m_ph = M_WAIT_AUTH;
        M_DRAIN_RETRY: if (btn == 3'b000) begin m_ph = M_CHOOSING; m_age = 0; end
        default:       m_ph = M_OFF;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(session_open, voter_auth, vote_btn);
    #1;
  endtask

  task automatic start_session();
    session_open = 1'b0; voter_auth = 1'b0; vote_btn = 3'b000;
    tick();
    session_open = 1'b1;
    tick();
  endtask

  task automatic do_cast(input logic [2:0] b);
    voter_auth = 1'b1; tick(); voter_auth = 1'b0;
    vote_btn = b;
    repeat (6) tick();
    vote_btn = 3'b000;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; session_open = 1'b0; voter_auth = 1'b0; vote_btn = 3'b000;
    model_reset();
    #12;
    checks++;
    if ({vote_pulse, reject_pulse, timeout_pulse, candidate_ready, cast_count} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {vote_pulse, reject_pulse, timeout_pulse, candidate_ready, cast_count});
    end
    checks++;
    if (state_o !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_o, S_IDLE); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single_vote();
    int seen, at; logic [2:0] pv;
    seen = 0; at = -1; pv = 3'b000;
    start_session();
    voter_auth = 1'b1; tick(); voter_auth = 1'b0;
    checks++;
    if (candidate_ready !== 1'b1) begin failures++; $display("FAIL armed_ready got=%b exp=1", candidate_ready); end
    vote_btn = 3'b010;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vote_pulse !== 3'b000) begin seen++; at = i; pv = vote_pulse; end
      if (i == 5) vote_btn = 3'b000;
    end
    checks++;
    if (seen !== 1) begin failures++; $display("FAIL single_vote_count got=%0d exp=1", seen); end
    checks++;
    if (at !== DEB + 1) begin failures++; $display("FAIL single_vote_latency got=%0d exp=%0d", at, DEB + 1); end
    checks++;
    if (pv !== 3'b010) begin failures++; $display("FAIL single_vote_value got=%b exp=010", pv); end
    checks++;
    if (cast_count !== 8'd1) begin failures++; $display("FAIL single_vote_cnt got=%0d exp=1", cast_count); end
    checks++;
    if (state_o !== S_READY) begin failures++; $display("FAIL single_vote_state got=%0d exp=%0d", state_o, S_READY); end
  endtask

  task automatic test_reject();
    int rejects, at; logic [2:0] pv;
    rejects = 0; at = -1; pv = 3'b000;
    start_session();
    voter_auth = 1'b1; tick(); voter_auth = 1'b0;
    vote_btn = 3'b101; tick();
    checks++;
    if (reject_pulse !== 1'b1) begin failures++; $display("FAIL reject_pulse got=%b exp=1", reject_pulse); end
    checks++;
    if (state_o !== S_WAIT_CLR) begin failures++; $display("FAIL reject_state got=%0d exp=%0d", state_o, S_WAIT_CLR); end
    tick();
    if (reject_pulse === 1'b1) rejects++;
    vote_btn = 3'b000; tick();
    if (reject_pulse === 1'b1) rejects++;
    checks++;
    if (state_o !== S_ARMED) begin failures++; $display("FAIL reject_rearm got=%0d exp=%0d", state_o, S_ARMED); end
    vote_btn = 3'b001;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (reject_pulse === 1'b1) rejects++;
      if (vote_pulse !== 3'b000) begin at = i; pv = vote_pulse; end
      if (i == 5) vote_btn = 3'b000;
    end
    checks++;
    if (rejects !== 0) begin failures++; $display("FAIL reject_once extra=%0d exp=0", rejects); end
    checks++;
    if (pv !== 3'b001 || at !== DEB + 1) begin failures++; $display("FAIL reject_revote got=%b@%0d exp=001@%0d", pv, at, DEB + 1); end
    checks++;
    if (cast_count !== 8'd1) begin failures++; $display("FAIL reject_cnt got=%0d exp=1", cast_count); end
  endtask

  task automatic test_bounce();
    int seen;
    seen = 0;
    start_session();
    voter_auth = 1'b1; tick(); voter_auth = 1'b0;
    vote_btn = 3'b100;
    tick(); if (vote_pulse !== 3'b000) seen++;
    tick(); if (vote_pulse !== 3'b000) seen++;
    vote_btn = 3'b000;
    tick(); if (vote_pulse !== 3'b000) seen++;
    checks++;
    if (state_o !== S_ARMED) begin failures++; $display("FAIL bounce_state got=%0d exp=%0d", state_o, S_ARMED); end
    repeat (3) begin tick(); if (vote_pulse !== 3'b000) seen++; end
    checks++;
    if (seen !== 0 || cast_count !== 8'd0) begin
      failures++; $display("FAIL bounce_novote pulses=%0d cnt=%0d exp=0,0", seen, cast_count);
    end
  endtask

  task automatic test_timeout();
    int at, n;
    at = -1; n = 0;
    start_session();
    do_cast(3'b100);
    voter_auth = 1'b1; tick(); voter_auth = 1'b0;
    for (int i = 1; i < 25; i++) begin
      tick();
      if (timeout_pulse === 1'b1) begin n++; if (at < 0) at = i; end
      if (i == TMO - 1) begin
        checks++;
        if (candidate_ready !== 1'b1) begin failures++; $display("FAIL timeout_armed got=%b exp=1", candidate_ready); end
      end
    end
    checks++;
    if (at !== TMO || n !== 1) begin failures++; $display("FAIL timeout_pulse got=%0d@%0d exp=1@%0d", n, at, TMO); end
    checks++;
    if (state_o !== S_READY || candidate_ready !== 1'b0) begin
      failures++; $display("FAIL timeout_state got=%0d/%b exp=%0d/0", state_o, candidate_ready, S_READY);
    end
    checks++;
    if (cast_count !== 8'd1) begin failures++; $display("FAIL timeout_cnt got=%0d exp=1", cast_count); end
  endtask

  task automatic test_session_close();
    int seen;
    seen = 0;
    start_session();
    voter_auth = 1'b1; tick(); voter_auth = 1'b0;
    vote_btn = 3'b010;
    repeat (3) tick();
    session_open = 1'b0;
    tick();
    vote_btn = 3'b000;
    checks++;
    if (state_o !== S_IDLE || candidate_ready !== 1'b0) begin
      failures++; $display("FAIL close_debounce got=%0d/%b exp=%0d/0", state_o, candidate_ready, S_IDLE);
    end
    repeat (4) begin tick(); if (vote_pulse !== 3'b000) seen++; end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL close_novote pulses=%0d exp=0", seen); end
    session_open = 1'b1; tick();
    voter_auth = 1'b1; tick(); voter_auth = 1'b0;
    vote_btn = 3'b001;
    repeat (6) tick();
    checks++;
    if (vote_pulse !== 3'b001) begin failures++; $display("FAIL close_cast_pulse got=%b exp=001", vote_pulse); end
    session_open = 1'b0; vote_btn = 3'b000;
    tick();
    checks++;
    if (state_o !== S_IDLE || cast_count !== 8'd1 || vote_pulse !== 3'b000) begin
      failures++; $display("FAIL close_in_cast st=%0d cnt=%0d vp=%b exp=%0d,1,000", state_o, cast_count, vote_pulse, S_IDLE);
    end
    tick();
    checks++;
    if (cast_count !== 8'd1) begin failures++; $display("FAIL idle_hold_cnt got=%0d exp=1", cast_count); end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    start_session();
    voter_auth = 1'b1; tick(); voter_auth = 1'b0;
    vote_btn = 3'b100;
    repeat (3) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({vote_pulse, reject_pulse, timeout_pulse, candidate_ready, cast_count, state_o} !== {14'd0, S_IDLE}) begin
      failures++; $display("FAIL reset_async got=%b/%0d exp=0/%0d",
        {vote_pulse, reject_pulse, timeout_pulse, candidate_ready, cast_count}, state_o, S_IDLE);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vote_pulse !== 3'b000) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL reset_novote pulses=%0d exp=0", seen); end
    vote_btn = 3'b000;
  endtask

  task automatic test_saturate();
    start_session();
    for (int i = 0; i < CMAX; i++) do_cast(3'b001 << $urandom_range(0, 2));
    checks++;
    if (cast_count !== 8'd255) begin failures++; $display("FAIL sat_reach got=%0d exp=255", cast_count); end
    do_cast(3'b010);
    checks++;
    if (cast_count !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", cast_count); end
    session_open = 1'b0; tick();
    session_open = 1'b1; tick();
    checks++;
    if (cast_count !== 8'd0) begin failures++; $display("FAIL sat_clear got=%0d exp=0", cast_count); end
  endtask

  task automatic test_random();
    logic [2:0]  pat;
    logic [2:0]  mt [4];
    logic [13:0] got, exp;
    int          r, closed;
    mt[0] = 3'b011; mt[1] = 3'b101; mt[2] = 3'b110; mt[3] = 3'b111;
    pat = 3'b000; closed = 0;
    session_open = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (closed > 0) begin
        closed--;
        if (closed == 0) session_open = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        session_open = 1'b0;
        closed = $urandom_range(1, 3);
      end
      voter_auth = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4)      pat = 3'b000;
        else if (r < 9) pat = 3'b001 << $urandom_range(0, 2);
        else            pat = mt[$urandom_range(0, 3)];
      end
      vote_btn = pat;
      tick();
      exp = {(m_ph == M_EMIT) ? m_choice : 3'b000, m_rej, m_to,
             (m_ph == M_CHOOSING || m_ph == M_HOLDING), m_count[CW-1:0]};
      got = {vote_pulse, reject_pulse, timeout_pulse, candidate_ready, cast_count};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random_cycle c=%0d got=%b exp=%b", c, got, exp);
      end
    end
    voter_auth = 1'b0; vote_btn = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single_vote();
    test_reject();
    test_bounce();
    test_timeout();
    test_session_close();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
